fdiv_iter: RTL and testbench

Iterative single-precision floating-point divider that computes x / y with a restoring radix-2 mantissa divider. It pairs with the pipelined fractional multiplier in the FPU divide path: that block multiplies mantissas, and this block divides them, producing a rounded IEEE-754 binary32 quotient. It sits behind a valid/ready handshake so the FPU issue logic can stall on it. It accepts one operation at a time.

---
 rtl/fdiv_iter_pkg.sv | 38 +++
 rtl/fdiv_round_pack.sv | 69 ++++++
 rtl/fdiv_iter.sv | 117 +++++++++++
 tb/tb_fdiv_iter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_iter_pkg.sv
// Shared FPU divide-path definitions: FSM states, special-case codes and binary32 constants.
package fdiv_iter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND,
        DONE
    } fdiv_state_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_INF,
        SP_ZERO
    } fdiv_special_t;

    localparam int unsigned EXP_BIAS          = 127;
    localparam logic [31:0] FP_INF_POS        = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO           = 32'h0000_0000;
    localparam int unsigned FDIV_ITER_DEFAULT = 26;

    // Priority order matters: a zero divisor wins over everything, including 0/0.
    function automatic fdiv_special_t fdiv_classify(input logic [7:0] ex, input logic [7:0] ey);
        fdiv_special_t sp;
        if (ey == 8'd0)
            sp = SP_INF;
        else if (ex == 8'd255)
            sp = SP_INF;
        else if (ex == 8'd0)
            sp = SP_ZERO;
        else if (ey == 8'd255)
            sp = SP_ZERO;
        else
            sp = SP_NONE;
        return sp;
    endfunction

endpackage

// File: rtl/fdiv_round_pack.sv
// Normalises the raw quotient, rounds to nearest even and packs the binary32 result.
module fdiv_round_pack
    import fdiv_iter_pkg::*;
#(
    parameter int unsigned ITER = FDIV_ITER_DEFAULT
) (
    input  logic [ITER-1:0]    q,
    input  logic               rem_nz,
    input  logic signed [9:0]  exp_diff,
    input  logic               sign,
    input  fdiv_special_t      special,
    output logic [31:0]        res
);

    localparam logic [ITER-1:0] ONE     = {{(ITER-1){1'b0}}, 1'b1};
    // Quotient bits below the guard position, for either normalisation.
    localparam logic [ITER-1:0] HI_MASK = (ONE << (ITER-25)) - ONE;
    localparam logic [ITER-1:0] LO_MASK = (ONE << (ITER-26)) - ONE;
    localparam logic signed [9:0] BIAS  = $signed(10'(EXP_BIAS));

    logic [22:0]        mant;
    logic               guard;
    logic               sticky;
    logic               up;
    logic [23:0]        mant_inc;
    logic signed [9:0]  e_norm;
    logic signed [9:0]  e_rnd;
    logic [31:0]        sign_word;

    always_comb begin
        mant     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        e_norm   = '0;
        if (q[ITER-1]) begin
            mant   = q[ITER-2 -: 23];
            guard  = q[ITER-25];
            sticky = rem_nz | (|(q & HI_MASK));
            e_norm = exp_diff + BIAS;
        end else begin
            mant   = q[ITER-3 -: 23];
            guard  = q[ITER-26];
            sticky = rem_nz | (|(q & LO_MASK));
            e_norm = exp_diff + BIAS - 10'sd1;
        end
        up       = guard & (sticky | mant[0]);
        mant_inc = {1'b0, mant} + {23'b0, up};
        // A carry out of the mantissa leaves the low 23 bits zero and bumps the exponent.
        e_rnd    = e_norm + $signed({9'b0, mant_inc[23]});
    end

    always_comb begin
        sign_word = {sign, 31'b0};
        res       = FP_ZERO;
        case (special)
            SP_INF:  res = FP_INF_POS | sign_word;
            SP_ZERO: res = FP_ZERO | sign_word;
            default: begin
                if (e_rnd <= 10'sd0)
                    res = FP_ZERO | sign_word;
                else if (e_rnd >= 10'sd255)
                    res = FP_INF_POS | sign_word;
                else
                    res = {sign, e_rnd[7:0], mant_inc[22:0]};
            end
        endcase
    end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative binary32 divider: restoring radix-2 mantissa division behind valid/ready handshakes.
module fdiv_iter
    import fdiv_iter_pkg::*;
#(
    parameter int unsigned ITER = FDIV_ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res
);

    localparam int unsigned     CW       = $clog2(ITER);
    localparam logic [CW-1:0]   CNT_LAST = CW'(ITER - 1);

    fdiv_state_t        state;
    fdiv_state_t        state_next;
    fdiv_special_t      special;
    fdiv_special_t      special_in;

    logic [CW-1:0]      cnt;
    logic [ITER-1:0]    q;
    logic [24:0]        r;
    logic [23:0]        b;
    logic signed [9:0]  exp_diff;
    logic               sign;
    logic               accept;
    logic               q_bit;
    logic [24:0]        r_sub;
    logic [31:0]        res_pack;

    assign special_in = fdiv_classify(x[30:23], y[30:23]);
    assign accept     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (special_in == SP_NONE) ? DIV : ROUND;
            DIV:     if (cnt == CNT_LAST) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        q_bit = (r >= {1'b0, b});
        r_sub = q_bit ? (r - {1'b0, b}) : r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            b        <= '0;
            exp_diff <= '0;
            sign     <= 1'b0;
            special  <= SP_NONE;
            res      <= FP_ZERO;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    r        <= {2'b01, x[22:0]};
                    b        <= {1'b1, y[22:0]};
                    q        <= '0;
                    cnt      <= '0;
                    exp_diff <= $signed({2'b00, x[30:23]}) - $signed({2'b00, y[30:23]});
                    sign     <= x[31] ^ y[31];
                    special  <= special_in;
                end
                DIV: begin
                    q <= {q[ITER-2:0], q_bit};
                    r <= r_sub << 1;
                    if (cnt != CNT_LAST)
                        cnt <= cnt + CW'(1);
                end
                ROUND: res <= res_pack;
                default: ;
            endcase
        end
    end

    fdiv_round_pack #(
        .ITER(ITER)
    ) u_round_pack (
        .q        (q),
        .rem_nz   (|r),
        .exp_diff (exp_diff),
        .sign     (sign),
        .special  (special),
        .res      (res_pack)
    );

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter with an arithmetic reference model and per-cycle output checks.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    bit          m_busy = 1'b0;
    int          m_age  = 0;
    int          m_lat  = 0;
    logic [31:0] m_res  = '0;

    always #5 clk = ~clk;

    fdiv_iter #(
        .ITER(26)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_special(input logic [31:0] xx, input logic [31:0] yy);
        return (xx[30:23] == 8'd0) || (xx[30:23] == 8'd255) ||
               (yy[30:23] == 8'd0) || (yy[30:23] == 8'd255);
    endfunction

    // Exact quotient with a 24-bit significand, rounded by comparing twice the remainder with b.
    function automatic logic [31:0] model_div(input logic [31:0] xx, input logic [31:0] yy);
        logic   s;
        int     ex, ey, e;
        longint a, b, num, m, rem;
        s  = xx[31] ^ yy[31];
        ex = int'(xx[30:23]);
        ey = int'(yy[30:23]);
        if (ey == 0 || ex == 255) return {s, 31'h7F80_0000};
        if (ex == 0 || ey == 255) return {s, 31'h0};
        a = longint'({1'b1, xx[22:0]});
        b = longint'({1'b1, yy[22:0]});
        if (a >= b) begin
            e   = ex - ey + 127;
            num = a << 23;
        end else begin
            e   = ex - ey + 126;
            num = a << 24;
        end
        m   = num / b;
        rem = num % b;
        if ((2 * rem > b) || ((2 * rem == b) && m[0])) m++;
        if (m == (longint'(1) << 24)) begin
            m = longint'(1) << 23;
            e++;
        end
        if (e <= 0)   return {s, 31'h0};
        if (e >= 255) return {s, 31'h7F80_0000};
        return {s, 8'(e), m[22:0]};
    endfunction

    // Transaction-level view of the block: idle, or holding one result that appears after its latency.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_lat  = is_special(x, y) ? 1 : 27;
                m_res  = model_div(x, y);
            end
        end else if (m_age >= m_lat) begin
            if (out_ready) m_busy = 1'b0;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready", 32'(in_ready), 32'(!m_busy));
            chk("cyc_out_valid", 32'(out_valid), 32'(m_busy && (m_age >= m_lat)));
            if (m_busy && (m_age >= m_lat))
                chk("cyc_res", res, m_res);
        end
    end

    task automatic run_op(input string name, input logic [31:0] xv, input logic [31:0] yv,
                          input logic [31:0] lit, input int lat_exp, input int hold, input bit poke);
        int n;
        chk({name, "_model"}, model_div(xv, yv), lit);
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_ready_wait"}, 32'(in_ready), 32'd1);
        x        = xv;
        y        = yv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x        = $urandom;
        y        = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin
            in_valid = poke && (n < 3);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk({name, "_latency"}, 32'(n), 32'(lat_exp));
        chk({name, "_res"}, res, lit);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_res"}, res, lit);
            chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({name, "_hold_out_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        chk({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_res", res, 32'h0000_0000);
        rst    = 1'b0;
        chk_en = 1'b1;

        run_op("one_div_one",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 27, 0, 1'b0);
        run_op("one_div_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 27, 0, 1'b0);
        run_op("neg_one_three", 32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 27, 0, 1'b1);
        run_op("six_div_two",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 27, 0, 1'b0);
        run_op("two_div_three", 32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 27, 0, 1'b0);
        run_op("three_div_two", 32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 27, 0, 1'b0);
        run_op("negs_6_2",      32'hC0C0_0000, 32'hC000_0000, 32'h4040_0000, 27, 0, 1'b0);
        run_op("div_by_zero",   32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 1, 0, 1'b0);
        run_op("zero_div_neg",  32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1, 0, 1'b0);
        run_op("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 1, 0, 1'b0);
        run_op("ninf_div_two",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1, 0, 1'b0);
        run_op("two_div_inf",   32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1, 0, 1'b0);
        run_op("denorm_flush",  32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 1, 0, 1'b0);
        run_op("overflow",      32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 27, 0, 1'b0);
        run_op("underflow",     32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 27, 0, 1'b0);
        run_op("hold_done",     32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 27, 5, 1'b0);

        // Abort an operation ten iterations into the divide.
        x        = 32'h3F80_0000;
        y        = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        run_op("after_abort",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 27, 0, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
